// File: rtl/rs_latch_driver.sv
// Clocked driver for a NAND RS latch: handshake-accepted set/reset commands become
// fixed-width active-low pulses, followed by dead time and a bounded feedback check.
module rs_latch_driver #(
  parameter int PULSE_CYCLES  = 2,
  parameter int DEAD_CYCLES   = 1,
  parameter int CHECK_TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_set,
  output logic cmd_ready,
  output logic s_n,
  output logic r_n,
  input  logic q_fb,
  input  logic q_bar_fb,
  output logic busy,
  output logic done,
  output logic err,
  output logic state_q,
  output logic state_vld
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // PULSE | selected line held low for PULSE_CYCLES
  // DEAD  | both lines high for DEAD_CYCLES
  // CHECK | both lines high, waiting up to CHECK_TIMEOUT cycles for feedback
  typedef enum logic [1:0] {IDLE, PULSE, DEAD, CHECK} state_t;

  localparam int MAX_A = (PULSE_CYCLES > DEAD_CYCLES) ? PULSE_CYCLES : DEAD_CYCLES;
  localparam int MAX_V = (MAX_A > CHECK_TIMEOUT) ? MAX_A : CHECK_TIMEOUT;
  localparam int CW    = $clog2(MAX_V + 1);

  localparam logic [CW-1:0] P_LD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] D_LD = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [CW-1:0] T_LD = CW'(CHECK_TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_target;
  logic          w_target_nxt;
  logic          w_accept;
  logic          w_match;
  logic          w_done_nxt;
  logic          w_err_nxt;
  logic          w_s_n_nxt;
  logic          w_r_n_nxt;
  logic          r_s_n;
  logic          r_r_n;
  logic          r_done;
  logic          r_err;
  logic          r_state_q;
  logic          r_state_vld;

  // q_fb == q_bar_fb can never satisfy this, so an illegal latch state is a mismatch
  assign w_match = (q_fb == r_target) && (q_bar_fb == ~r_target);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_target    <= 1'b0;
      r_s_n       <= 1'b1;
      r_r_n       <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_state_q   <= 1'b0;
      r_state_vld <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_target <= w_target_nxt;
      r_s_n    <= w_s_n_nxt;
      r_r_n    <= w_r_n_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      if (w_done_nxt) begin
        r_state_q   <= r_target;
        r_state_vld <= 1'b1;
      end else if (w_err_nxt) begin
        r_state_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt == '0) ? '0 : r_cnt - CW'(1);
    w_accept    = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = PULSE;
          w_cnt_nxt   = P_LD;
        end
      end
      PULSE: begin
        if (r_cnt == '0) begin
          if (DEAD_CYCLES == 0) begin
            w_state_nxt = CHECK;
            w_cnt_nxt   = T_LD;
          end else begin
            w_state_nxt = DEAD;
            w_cnt_nxt   = D_LD;
          end
        end
      end
      DEAD: begin
        if (r_cnt == '0) begin
          w_state_nxt = CHECK;
          w_cnt_nxt   = T_LD;
        end
      end
      CHECK: begin
        if (w_match) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // line drives are decoded from the next state so they are registered yet start the cycle after accept
  always_comb begin
    w_target_nxt = w_accept ? cmd_set : r_target;
    w_s_n_nxt    = !((w_state_nxt == PULSE) && w_target_nxt);
    w_r_n_nxt    = !((w_state_nxt == PULSE) && !w_target_nxt);
  end

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign s_n       = r_s_n;
  assign r_n       = r_r_n;
  assign done      = r_done;
  assign err       = r_err;
  assign state_q   = r_state_q;
  assign state_vld = r_state_vld;

endmodule

// File: tb/tb_rs_latch_driver.sv
// Bench for rs_latch_driver: a NAND latch model supplies feedback, a scoreboard
// holds the expected outcome and timing of every accepted command.
module tb_rs_latch_driver;
  localparam int P = 2;
  localparam int D = 1;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_set, cmd_ready, s_n, r_n, q_fb, q_bar_fb;
  logic busy, done, err, state_q, state_vld;

  typedef struct {
    logic tgt;
    logic exp_err;
    int   acc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_acc   = 0;
  int   n_rst   = 0;
  int   last_acc = 0;
  int   n_overlap = 0;
  int   fb_mode = 0;
  logic lq = 1'b0;

  rs_latch_driver #(.PULSE_CYCLES(P), .DEAD_CYCLES(D), .CHECK_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_set(cmd_set), .cmd_ready(cmd_ready),
    .s_n(s_n), .r_n(r_n), .q_fb(q_fb), .q_bar_fb(q_bar_fb), .busy(busy), .done(done),
    .err(err), .state_q(state_q), .state_vld(state_vld)
  );

  always #5 clk = ~clk;

  // behavioural NAND latch; fb_mode 1 = stuck q=0/q_bar=1, 2 = both high
  always @(negedge clk) begin
    if (!s_n) lq <= 1'b1;
    else if (!r_n) lq <= 1'b0;
  end
  assign q_fb     = (fb_mode == 0) ? lq : (fb_mode == 1) ? 1'b0 : 1'b1;
  assign q_bar_fb = (fb_mode == 0) ? ~lq : 1'b1;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
    end else if (cmd_valid && cmd_ready) begin
      sb.push_back('{tgt: cmd_set, exp_err: (fb_mode != 0), acc: cyc});
      n_acc++;
      last_acc = cyc;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   rel;
    int   exp_rel;
    n_tests++;
    if (s_n === 1'b0 && r_n === 1'b0) begin
      n_fail++;
      n_overlap++;
      $display("FAIL overlap: s_n=%b r_n=%b at cycle %0d, required not both 0", s_n, r_n, cyc);
    end
    if (done === 1'b1 || err === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: done=%b err=%b at cycle %0d with no pending command", done, err, cyc);
      end else begin
        e = sb.pop_front();
        rel = cyc - e.acc + 1;
        exp_rel = e.exp_err ? (P + D + T + 1) : (P + D + 2);
        if (done !== !e.exp_err || err !== e.exp_err || rel !== exp_rel) begin
          n_fail++;
          $display("FAIL result: done=%b err=%b rel_cycle=%0d, required done=%b err=%b rel_cycle=%0d",
                   done, err, rel, !e.exp_err, e.exp_err, exp_rel);
        end
        n_tests++;
        if (!e.exp_err && (state_q !== e.tgt || state_vld !== 1'b1)) begin
          n_fail++;
          $display("FAIL state_on_done: state_q=%b state_vld=%b, required %b 1", state_q, state_vld, e.tgt);
        end else if (e.exp_err && state_vld !== 1'b0) begin
          n_fail++;
          $display("FAIL state_on_err: state_vld=%b, required 0", state_vld);
        end
      end
    end
  end

  task automatic run_cmd(input logic set, output int acc, output int done_cyc, output int err_cyc,
                         output int lo_s, output int lo_r, output int s_first);
    int a0;
    a0 = n_acc; acc = -1; done_cyc = -1; err_cyc = -1; lo_s = 0; lo_r = 0; s_first = -1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_set   = set;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (n_acc != a0) begin
        cmd_valid = 1'b0;
        acc = last_acc;
      end
      if (!s_n) begin
        lo_s++;
        if (s_first < 0) s_first = cyc;
      end
      if (!r_n) lo_r++;
      if (done) done_cyc = cyc;
      if (err) err_cyc = cyc;
      if (n_acc != a0 && !busy && !done && !err && sb.size() == 0) return;
    end
    cmd_valid = 1'b0;
    n_tests++; n_fail++;
    $display("FAIL run_cmd_timeout: command set=%b not completed in 60 cycles", set);
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_set = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (s_n !== 1'b1 || r_n !== 1'b1 || done !== 1'b0 || err !== 1'b0 || state_vld !== 1'b0 || state_q !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: s_n=%b r_n=%b done=%b err=%b state_q=%b state_vld=%b, required 1 1 0 0 0 0",
               s_n, r_n, done, err, state_q, state_vld);
    end
    n_tests++;
    if (busy !== 1'b0 || n_acc !== 0) begin
      n_fail++;
      $display("FAIL reset_no_accept: busy=%b accepts=%0d, required 0 0", busy, n_acc);
    end
    rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_ready);
    end
  endtask

  task automatic test_set();
    int acc, dc, ec, ls, lr, sf;
    fb_mode = 0;
    run_cmd(1'b1, acc, dc, ec, ls, lr, sf);
    n_tests++;
    if (ls !== P || lr !== 0 || sf !== acc) begin
      n_fail++;
      $display("FAIL set_pulse: s_n low %0d cycles from rel %0d, r_n low %0d, required %0d from rel 1, 0",
               ls, sf - acc + 1, lr, P);
    end
    n_tests++;
    if (dc - acc + 1 !== P + D + 2 || ec !== -1) begin
      n_fail++;
      $display("FAIL set_done_cycle: done rel %0d err_seen=%0d, required rel %0d no err", dc - acc + 1, ec, P + D + 2);
    end
    n_tests++;
    if (state_q !== 1'b1 || state_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL set_state: state_q=%b state_vld=%b, required 1 1", state_q, state_vld);
    end
  endtask

  task automatic test_back_to_back();
    int a0, rlow, nd, rdy_bad, acc2;
    int dcyc[2];
    fb_mode = 0; a0 = n_acc; rlow = 0; nd = 0; rdy_bad = 0; acc2 = -1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_set = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (n_acc == a0 + 1) cmd_set = 1'b0;
      if (n_acc == a0 + 2) begin
        cmd_valid = 1'b0;
        if (acc2 < 0) acc2 = last_acc;
      end
      if (busy && cmd_ready !== 1'b0) rdy_bad++;
      if (!r_n) rlow++;
      if (done && nd < 2) begin
        dcyc[nd] = cyc;
        nd++;
      end
      if (n_acc == a0 + 2 && !busy && !done && sb.size() == 0) break;
    end
    cmd_valid = 1'b0;
    n_tests++;
    if (nd !== 2 || rdy_bad !== 0) begin
      n_fail++;
      $display("FAIL b2b_handshake: dones=%0d ready_while_busy=%0d, required 2 0", nd, rdy_bad);
    end else begin
      n_tests++;
      if (acc2 !== dcyc[0] + 1) begin
        n_fail++;
        $display("FAIL b2b_accept_edge: second accept at %0d, required %0d", acc2, dcyc[0] + 1);
      end
      n_tests++;
      if (dcyc[1] - dcyc[0] !== P + D + 2) begin
        n_fail++;
        $display("FAIL b2b_spacing: done spacing %0d, required %0d", dcyc[1] - dcyc[0], P + D + 2);
      end
    end
    n_tests++;
    if (rlow !== P || state_q !== 1'b0 || state_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_reset_cmd: r_n low %0d state_q=%b state_vld=%b, required %0d 0 1", rlow, state_q, state_vld, P);
    end
  endtask

  task automatic test_err_stuck();
    int acc, dc, ec, ls, lr, sf;
    fb_mode = 1;
    run_cmd(1'b1, acc, dc, ec, ls, lr, sf);
    fb_mode = 0;
    n_tests++;
    if (dc !== -1 || ec - acc + 1 !== P + D + T + 1) begin
      n_fail++;
      $display("FAIL err_stuck: done_seen=%0d err rel %0d, required none and rel %0d", dc, ec - acc + 1, P + D + T + 1);
    end
    n_tests++;
    if (state_vld !== 1'b0 || state_q !== 1'b0) begin
      n_fail++;
      $display("FAIL err_stuck_state: state_q=%b state_vld=%b, required 0 0", state_q, state_vld);
    end
  endtask

  task automatic test_illegal_fb();
    int acc, dc, ec, ls, lr, sf;
    fb_mode = 2;
    run_cmd(1'b0, acc, dc, ec, ls, lr, sf);
    fb_mode = 0;
    n_tests++;
    if (dc !== -1 || ec - acc + 1 !== P + D + T + 1 || lr !== P) begin
      n_fail++;
      $display("FAIL illegal_fb: done_seen=%0d err rel %0d r_n low %0d, required none, rel %0d, %0d",
               dc, ec - acc + 1, lr, P + D + T + 1, P);
    end
  endtask

  task automatic test_reset_mid();
    int acc, dc, ec, ls, lr, sf;
    int a0;
    fb_mode = 0;
    run_cmd(1'b1, acc, dc, ec, ls, lr, sf);
    a0 = n_acc;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_set = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_tests++;
    if (n_acc !== a0 + 1 || s_n !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_setup: accepts=%0d s_n=%b in second pulse cycle, required %0d 0", n_acc - a0, s_n, 1);
    end
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (s_n !== 1'b1 || r_n !== 1'b1 || done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_lines: s_n=%b r_n=%b done=%b err=%b busy=%b, required 1 1 0 0 0", s_n, r_n, done, err, busy);
    end
    n_tests++;
    if (state_q !== 1'b0 || state_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_state: state_q=%b state_vld=%b, required 0 0", state_q, state_vld);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_quiet: done=%b err=%b busy=%b after reset, required 0 0 0", done, err, busy);
      end
    end
  endtask

  task automatic test_random();
    int a0, r0, i;
    a0 = n_acc; r0 = n_rst; fb_mode = 0;
    for (i = 0; i < 20000 && (n_acc - a0) + (n_rst - r0) < 1000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 49) == 0);
      if (rst) n_rst++;
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_set   = $urandom_range(0, 1) == 1;
    end
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;
    for (int k = 0; k < 40 && (busy || sb.size() != 0); k++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_tests++;
    if ((n_acc - a0) + (n_rst - r0) < 1000 || sb.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL random_progress: events=%0d pending=%0d busy=%b, required >=1000 0 0",
               (n_acc - a0) + (n_rst - r0), sb.size(), busy);
    end
    n_tests++;
    if (n_overlap !== 0) begin
      n_fail++;
      $display("FAIL random_overlap: overlap cycles %0d, required 0", n_overlap);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_set = 1'b0;
    test_reset();
    test_set();
    test_back_to_back();
    test_err_stuck();
    test_illegal_fb();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
